// File: rtl/key_matrix_scan_if.sv
// Keypad-side signal bundle for key_matrix_scan: row sense in, column drive and key report out.
// master = keypad/host side, slave = the scanner.
interface key_matrix_scan_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    modport master (
        output row_in,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_down
    );

    modport slave (
        input  row_in,
        output col_out,
        output key_code,
        output key_valid,
        output key_down
    );
endinterface

// File: rtl/key_matrix_scan.sv
// 4x4 keypad scanner with per-tick column scan, press/release debounce and a one-cycle key_valid pulse.
// Optional macro KEY_REPEAT_EN adds auto-repeat pulses every REPEAT_TICKS ticks while a key is held.
module key_matrix_scan #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_TICKS = 20,
    parameter int unsigned REPEAT_TICKS   = 500
) (
    input  logic              clk,
    input  logic              rst,
    key_matrix_scan_if.slave  kp
);
    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    if (SCAN_DIV < 1 || DEBOUNCE_TICKS < 2 || REPEAT_TICKS < 1) begin : g_bad_params
        $error("key_matrix_scan: parameters out of range");
    end

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_e;

    state_e           state_q, state_d;
    logic [3:0]       sync1_q, sync2_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       col_q, col_d;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             down_q, down_d;
    logic             tick, any_low, same_key, cand_low, cnt_done;
    logic [1:0]       low_row;

`ifdef KEY_REPEAT_EN
    localparam int unsigned RPT_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_TICKS - 1);
    logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

    assign tick     = (div_q == DIV_LAST);
    assign any_low  = ~&sync2_q;
    assign same_key = any_low && (low_row == cand_q[1:0]);
    assign cand_low = ~sync2_q[cand_q[1:0]];
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign cnt_done = (cnt_inc == CNT_LAST);

    // Descending scan so the lowest-index low row wins.
    always_comb begin
        low_row = 2'd0;
        for (int unsigned i = 4; i > 0; i--) begin
            if (!sync2_q[i-1]) low_row = 2'(i - 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                IDLE:     if (any_low) state_d = DEBOUNCE;
                DEBOUNCE: if (!same_key) state_d = IDLE;
                          else if (cnt_done) state_d = PRESSED;
                PRESSED:  if (!cand_low) state_d = RELEASE;
                RELEASE:  if (cand_low) state_d = PRESSED;
                          else if (cnt_done) state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        col_d   = col_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = 1'b0;
        down_d  = down_q;
`ifdef KEY_REPEAT_EN
        rpt_d   = rpt_q;
`endif
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (any_low) begin
                        cand_d = {col_q, low_row};
                        cnt_d  = '0;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (!same_key) begin
                        col_d = col_q + 2'd1;
                    end else if (cnt_done) begin
                        code_d  = cand_q;
                        valid_d = 1'b1;
                        down_d  = 1'b1;
`ifdef KEY_REPEAT_EN
                        rpt_d   = '0;
`endif
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                PRESSED: begin
                    if (!cand_low) begin
                        cnt_d = '0;
                    end
`ifdef KEY_REPEAT_EN
                    else if (rpt_q == RPT_LAST) begin
                        valid_d = 1'b1;
                        rpt_d   = '0;
                    end else begin
                        rpt_d = rpt_q + RPT_W'(1);
                    end
`endif
                end
                RELEASE: begin
                    if (cand_low) begin
`ifdef KEY_REPEAT_EN
                        rpt_d = '0;
`endif
                    end else if (cnt_done) begin
                        down_d = 1'b0;
                        col_d  = col_q + 2'd1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
            div_q   <= '0;
            col_q   <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            down_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            sync1_q <= kp.row_in;
            sync2_q <= sync1_q;
            div_q   <= tick ? '0 : div_q + DIV_W'(1);
            col_q   <= col_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            down_q  <= down_d;
`ifdef KEY_REPEAT_EN
            rpt_q   <= rpt_d;
`endif
        end
    end

    assign kp.col_out   = ~(4'b0001 << col_q);
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_down  = down_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Directed bench for key_matrix_scan: a keypad model drives row_in from col_out, and a tick-level
// model of the scan/debounce rules is compared against the outputs on every falling clock edge.
module tb_key_matrix_scan;
    localparam int SD = 4;
    localparam int DB = 3;
    localparam int RP = 5;
`ifdef KEY_REPEAT_EN
    localparam int REPEAT_ON = 1;
`else
    localparam int REPEAT_ON = 0;
`endif

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic [15:0] keys = '0;
    int          n_chk  = 0;
    int          n_err  = 0;
    int          nvalid = 0;
    int          base;
    logic [3:0]  scan_seq [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    key_matrix_scan_if kp_if ();

    key_matrix_scan #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_TICKS (DB),
        .REPEAT_TICKS   (RP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp_if.slave)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        kp_if.row_in = '1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!kp_if.col_out[c] && keys[c*4+r]) kp_if.row_in[r] = 1'b0;
    end

    always @(posedge clk) if (kp_if.key_valid) nvalid <= nvalid + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] col_pattern(input int c);
        logic [3:0] one = 4'b0001;
        return ~(one << c);
    endfunction

    function automatic int lowest_pressed(input int c, input logic [15:0] k);
        for (int r = 0; r < 4; r++) if (k[c*4+r]) return r;
        return -1;
    endfunction

    // Reference model, evaluated once per scan tick in terms of agreeing-sample streaks.
    int         m_cyc, m_col, m_held, m_cand, m_streak, m_rel, m_rpt;
    logic [3:0] e_code;
    logic       e_valid, e_down;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc <= 0; m_col <= 0; m_held <= -1; m_cand <= 0;
            m_streak <= 0; m_rel <= 0; m_rpt <= 0;
            e_code <= '0; e_valid <= 1'b0; e_down <= 1'b0;
        end else begin
            e_valid <= 1'b0;
            m_cyc   <= (m_cyc + 1) % SD;
            if (m_cyc == SD - 1) begin
                if (m_held < 0) begin
                    if (m_streak == 0) begin
                        if (lowest_pressed(m_col, keys) >= 0) begin
                            m_cand   <= m_col * 4 + lowest_pressed(m_col, keys);
                            m_streak <= 1;
                        end else begin
                            m_col <= (m_col + 1) % 4;
                        end
                    end else if (lowest_pressed(m_col, keys) == m_cand % 4) begin
                        if (m_streak + 1 == DB) begin
                            m_held <= m_cand; m_streak <= 0; m_rel <= 0; m_rpt <= 0;
                            e_valid <= 1'b1; e_code <= 4'(m_cand); e_down <= 1'b1;
                        end else begin
                            m_streak <= m_streak + 1;
                        end
                    end else begin
                        m_streak <= 0;
                        m_col    <= (m_col + 1) % 4;
                    end
                end else if (keys[m_held]) begin
                    if (m_rel > 0) begin
                        m_rel <= 0; m_rpt <= 0;
                    end else if (REPEAT_ON != 0) begin
                        if (m_rpt + 1 == RP) begin
                            e_valid <= 1'b1; m_rpt <= 0;
                        end else begin
                            m_rpt <= m_rpt + 1;
                        end
                    end
                end else if (m_rel + 1 == DB) begin
                    m_held <= -1; m_rel <= 0; e_down <= 1'b0;
                    m_col  <= (m_held / 4 + 1) % 4;
                end else begin
                    m_rel <= m_rel + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_col_out",   kp_if.col_out,   col_pattern(m_col));
        check("cyc_key_code",  kp_if.key_code,  e_code);
        check("cyc_key_valid", kp_if.key_valid, e_valid);
        check("cyc_key_down",  kp_if.key_down,  e_down);
    end

    task automatic ticks(input int n);
        repeat (n * SD) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_col_out",   kp_if.col_out,   4'b1110);
        check("rst_key_code",  kp_if.key_code,  4'd0);
        check("rst_key_valid", kp_if.key_valid, 1'b0);
        check("rst_key_down",  kp_if.key_down,  1'b0);
        rst = 1'b0;

        // Idle scan: one column step per tick, wrapping 3 -> 0.
        for (int i = 0; i < 4; i++) begin
            ticks(1);
            check("scan_col_out", kp_if.col_out, scan_seq[i]);
        end
        check("scan_no_valid", nvalid, 0);

        // Key 6 (col 1, row 2) held for 20 ticks.
        keys[6] = 1'b1; base = nvalid;
        ticks(20);
        check("hold_valid_cnt", nvalid - base, (REPEAT_ON != 0) ? 4 : 1);
        check("hold_key_code",  kp_if.key_code, 4'd6);
        check("hold_key_down",  kp_if.key_down, 1'b1);
        check("hold_col_out",   kp_if.col_out,  4'b1101);

        keys[6] = 1'b0;
        ticks(4);
        check("rel_key_down", kp_if.key_down, 1'b0);
        check("rel_col_out",  kp_if.col_out,  4'b0111);

        // One-tick bounce on key 6.
        ticks(1);
        keys[6] = 1'b1; base = nvalid;
        ticks(2);
        keys[6] = 1'b0;
        ticks(1);
        check("bounce_col_out",  kp_if.col_out, 4'b1011);
        check("bounce_no_valid", nvalid - base, 0);
        check("bounce_key_down", kp_if.key_down, 1'b0);
        ticks(1);
        check("bounce_idle_col", kp_if.col_out, 4'b0111);

        // Rows 1 and 3 in column 0, then a release glitch, then full release.
        keys[1] = 1'b1; keys[3] = 1'b1; base = nvalid;
        ticks(7);
        check("multi_key_code", kp_if.key_code, 4'd1);
        check("multi_key_down", kp_if.key_down, 1'b1);
        check("multi_col_out",  kp_if.col_out,  4'b1110);
        keys[1] = 1'b0;
        ticks(1);
        keys[1] = 1'b1;
        ticks(3);
        check("glitch_key_down", kp_if.key_down, 1'b1);
        keys[1] = 1'b0; keys[3] = 1'b0;
        ticks(3);
        check("glitch_key_down_rel", kp_if.key_down, 1'b0);
        check("glitch_one_valid",    nvalid - base, 1);
        check("glitch_col_out",      kp_if.col_out, 4'b1101);

        // Reset while debouncing key 6.
        keys[6] = 1'b1;
        ticks(2);
        #2 rst = 1'b1;
        #1;
        check("arst_col_out",   kp_if.col_out,   4'b1110);
        check("arst_key_code",  kp_if.key_code,  4'd0);
        check("arst_key_valid", kp_if.key_valid, 1'b0);
        check("arst_key_down",  kp_if.key_down,  1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0; base = nvalid;
        ticks(2);
        check("post_rst_no_valid", nvalid - base, 0);
        check("post_rst_col_out",  kp_if.col_out, 4'b1101);
        ticks(3);
        check("post_rst_valid",    nvalid - base, 1);
        check("post_rst_key_code", kp_if.key_code, 4'd6);

        // Keep holding: repeat pulses at +5 and +10 ticks only when enabled.
        base = nvalid;
        ticks(11);
        check("repeat_valid_cnt", nvalid - base, (REPEAT_ON != 0) ? 2 : 0);
        check("repeat_key_code",  kp_if.key_code, 4'd6);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
